prio_enc_debounced: RTL and testbench

//  Parametrised, registered N-input priority encoder for push-button banks (pb[]).

---
 rtl/prio_enc_debounced.sv | 200 ++++++++++++++++++++
 tb/tb_prio_enc_debounced.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_debounced.sv
// Debounced, registered priority encoder for a push-button bank; optional auto-repeat under KEY_REPEAT_EN.
// Latency: 2-flop sync plus DEBOUNCE samples; strobe is high the cycle after edge k+1+DEBOUNCE.
// Backpressure: none; strobe is a one-cycle pulse and code holds until the next accepted press.
module prio_enc_debounced #(
    parameter int N            = 20,
    parameter int W            = $clog2(N),
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic         hz100,
    input  logic         reset,
    input  logic [N-1:0] in,
    output logic [W-1:0] code,
    output logic         strobe,
    output logic         held,
    output logic         multi
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HELD, S_RELEASE} state_t;

    localparam int CW = $clog2(DEBOUNCE + 1);

    if (N < 2 || N > 64 || DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 || W != $clog2(N))
    begin : g_param_check
        $error("prio_enc_debounced: parameter out of range");
    end

    logic          rst_meta;
    logic          rst_n;
    logic [N-1:0]  s_meta;
    logic [N-1:0]  s;
    logic [W-1:0]  idx;
    logic          any;
    state_t        state;
    state_t        state_n;
    logic [W-1:0]  cand;
    logic [W-1:0]  cand_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] cnt_inc;
    logic [W-1:0]  code_n;
    logic          strobe_n;
    logic          arm;
    logic          accept;
    logic          rep_fire;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    always_ff @(posedge hz100 or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= '0;
            s      <= '0;
        end else begin
            s_meta <= in;
            s      <= s_meta;
        end
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i]) idx = W'(i);
        end
    end

    assign any = |s;

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        code_n   = code;
        strobe_n = 1'b0;
        arm      = 1'b0;
        accept   = 1'b0;
        cnt_inc  = cnt + CW'(1);
        unique case (state)
            S_IDLE: begin
                if (any) arm = 1'b1;
            end
            S_ARM: begin
                if (!any) begin
                    state_n = S_IDLE;
                end else if (idx != cand) begin
                    arm = 1'b1;
                end else if (cnt_inc == CW'(DEBOUNCE)) begin
                    accept = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_HELD: begin
                if (!any) begin
                    if (DEBOUNCE == 1) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_RELEASE;
                        cnt_n   = CW'(1);
                    end
                end else if (idx != code) begin
                    arm = 1'b1;
                end
            end
            S_RELEASE: begin
                if (any) begin
                    if (idx == code) state_n = S_HELD;
                    else             arm     = 1'b1;
                end else if (cnt_inc == CW'(DEBOUNCE)) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // The first sample of a new candidate already counts toward the debounce window.
        if (arm) begin
            cand_n = idx;
            cnt_n  = CW'(1);
            if (DEBOUNCE == 1) accept  = 1'b1;
            else               state_n = S_ARM;
        end
        if (accept) begin
            state_n  = S_HELD;
            code_n   = cand_n;
            strobe_n = 1'b1;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0] rep;
    logic [RW-1:0] rep_n;
    logic [RW-1:0] rep_inc;
    logic          rep_phase;
    logic          rep_phase_n;

    // Phase 0 waits REPEAT_DELAY after entering HELD, phase 1 repeats every REPEAT_RATE.
    always_comb begin
        rep_n       = '0;
        rep_phase_n = 1'b0;
        rep_fire    = 1'b0;
        rep_inc     = rep + RW'(1);
        if (state == S_HELD && state_n == S_HELD && !accept) begin
            if (rep_inc == (rep_phase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY))) begin
                rep_fire    = 1'b1;
                rep_phase_n = 1'b1;
            end else begin
                rep_n       = rep_inc;
                rep_phase_n = rep_phase;
            end
        end
    end

    always_ff @(posedge hz100 or negedge rst_n) begin
        if (!rst_n) begin
            rep       <= '0;
            rep_phase <= 1'b0;
        end else begin
            rep       <= rep_n;
            rep_phase <= rep_phase_n;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge hz100 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cand   <= '0;
            cnt    <= '0;
            code   <= '0;
            strobe <= 1'b0;
            multi  <= 1'b0;
        end else begin
            state  <= state_n;
            cand   <= cand_n;
            cnt    <= cnt_n;
            code   <= code_n;
            strobe <= strobe_n | rep_fire;
            multi  <= |(s & (s - N'(1)));
        end
    end

    assign held = (state == S_HELD) || (state == S_RELEASE);

endmodule

// File: tb/tb_prio_enc_debounced.sv
// Self-checking bench for prio_enc_debounced: directed scenarios plus random presses,
// each cycle compared against a run-length reference model of the debounce rules.
module tb_prio_enc_debounced;

    localparam int N  = 20;
    localparam int W  = 5;
    localparam int D  = 4;
    localparam int RD = 50;
    localparam int RR = 10;

    logic         hz100 = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] in    = '0;
    logic [W-1:0] code;
    logic         strobe;
    logic         held;
    logic         multi;

    int checks = 0;
    int passes = 0;

    prio_enc_debounced #(
        .N(N), .W(W), .DEBOUNCE(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .hz100(hz100), .reset(reset), .in(in),
        .code(code), .strobe(strobe), .held(held), .multi(multi)
    );

    always #5 hz100 = ~hz100;

    // Reference model: s is in delayed two edges; a key is accepted when the same
    // winner has been seen for D consecutive samples, released after D empty samples.
    logic [N-1:0] m_s1 = '0;
    logic [N-1:0] m_s2 = '0;
    int  m_prev = -1, m_run = 0, m_code = 0, m_age = 0, m_rel = 0, m_v = -1;
    bit  m_held = 1'b0, m_strobe = 1'b0, m_multi = 1'b0;

    function automatic int top_bit(input logic [N-1:0] v);
        top_bit = -1;
        for (int i = 0; i < N; i++) if (v[i]) top_bit = i;
    endfunction

    always @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_prev = -1; m_run = 0; m_code = 0; m_age = 0; m_rel = 0;
            m_held = 1'b0; m_strobe = 1'b0; m_multi = 1'b0;
        end else if (m_rel < 2) begin
            m_rel++;
        end else begin
            m_v      = top_bit(m_s2);
            m_run    = (m_v == m_prev) ? m_run + 1 : 1;
            m_strobe = 1'b0;
            m_multi  = $countones(m_s2) > 1;
            if (m_v < 0) begin
                if (m_run >= D) m_held = 1'b0;
            end else if (m_held && m_v == m_code) begin
                if (m_prev < 0) begin
                    m_age = 0;
                end else begin
                    m_age++;
`ifdef KEY_REPEAT_EN
                    if (m_age >= RD && (m_age - RD) % RR == 0) m_strobe = 1'b1;
`endif
                end
            end else begin
                m_held = 1'b0;
                if (m_run == D) begin
                    m_held = 1'b1; m_code = m_v; m_strobe = 1'b1; m_age = 0;
                end
            end
            m_prev = m_v;
            m_s2   = m_s1;
            m_s1   = in;
        end
    end

    task automatic tick();
        @(posedge hz100);
        @(negedge hz100);
    endtask

    task automatic test_reset();
        int n = 0;
        logic [W-1:0] c = '0;
        #1 reset = 1'b0;
        in = '1;
        repeat (3) tick();
        checks++; if (code !== '0)    $display("FAIL reset_code got %0d want 0", code);   else passes++;
        checks++; if (strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", strobe); else passes++;
        checks++; if (held !== 1'b0)   $display("FAIL reset_held got %b want 0", held);     else passes++;
        checks++; if (multi !== 1'b0)  $display("FAIL reset_multi got %b want 0", multi);   else passes++;
        reset = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            checks++;
            if ({strobe, held, multi, code} !== {m_strobe, m_held, m_multi, m_code[W-1:0]})
                $display("FAIL reset_model t=%0d dut=%b/%b/%b/%0d model=%b/%b/%b/%0d", t,
                         strobe, held, multi, code, m_strobe, m_held, m_multi, m_code[W-1:0]);
            else passes++;
            if (strobe) begin n++; c = code; end
        end
        checks++; if (n !== 1)      $display("FAIL reset_release_strobes got %0d want 1", n); else passes++;
        checks++; if (c !== 5'd19)  $display("FAIL reset_release_code got %0d want 19", c);   else passes++;
        checks++; if (multi !== 1'b1) $display("FAIL reset_release_multi got %b want 1", multi); else passes++;
        in = '0;
        repeat (10) tick();
        checks++; if (held !== 1'b0) $display("FAIL reset_settle_held got %b want 0", held); else passes++;
    endtask

    task automatic test_single_press();
        int first = 0, n = 0;
        logic [W-1:0] c = '0;
        in = '0; in[7] = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            checks++;
            if ({strobe, held, multi, code} !== {m_strobe, m_held, m_multi, m_code[W-1:0]})
                $display("FAIL press_model t=%0d dut=%b/%b/%b/%0d model=%b/%b/%b/%0d", t,
                         strobe, held, multi, code, m_strobe, m_held, m_multi, m_code[W-1:0]);
            else passes++;
            if (strobe) begin n++; if (first == 0) begin first = t; c = code; end end
        end
        checks++; if (first !== 6)  $display("FAIL press_latency got tick %0d want 6", first); else passes++;
        checks++; if (c !== 5'd7)   $display("FAIL press_code got %0d want 7", c);            else passes++;
        checks++; if (n !== 1)      $display("FAIL press_strobes got %0d want 1", n);         else passes++;
        checks++; if (held !== 1'b1) $display("FAIL press_held got %b want 1", held);         else passes++;
        in = '0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 5) begin
                checks++; if (held !== 1'b1) $display("FAIL release_held_t5 got %b want 1", held); else passes++;
            end
            if (t == 6) begin
                checks++; if (held !== 1'b0) $display("FAIL release_held_t6 got %b want 0", held); else passes++;
            end
        end
    endtask

    task automatic test_glitch();
        int n = 0;
        in = '0; in[3] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            if (t == 3) in = '0;
            tick();
            checks++;
            if ({strobe, held, multi, code} !== {m_strobe, m_held, m_multi, m_code[W-1:0]})
                $display("FAIL glitch_model t=%0d dut=%b/%b/%b/%0d model=%b/%b/%b/%0d", t,
                         strobe, held, multi, code, m_strobe, m_held, m_multi, m_code[W-1:0]);
            else passes++;
            if (strobe) n++;
        end
        checks++; if (n !== 0)      $display("FAIL glitch_strobes got %0d want 0", n);  else passes++;
        checks++; if (code !== 5'd7) $display("FAIL glitch_code got %0d want 7", code); else passes++;
        checks++; if (held !== 1'b0) $display("FAIL glitch_held got %b want 0", held);  else passes++;
    endtask

    task automatic test_priority();
        logic [W-1:0] got[$];
        int  exp_codes[3] = '{2, 15, 2};
        logic saw_multi = 1'b0;
        in = '0; in[2] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (t == 10) in[15] = 1'b1;
            if (t == 20) in[15] = 1'b0;
            if (t == 30) in = '0;
            tick();
            checks++;
            if ({strobe, held, multi, code} !== {m_strobe, m_held, m_multi, m_code[W-1:0]})
                $display("FAIL prio_model t=%0d dut=%b/%b/%b/%0d model=%b/%b/%b/%0d", t,
                         strobe, held, multi, code, m_strobe, m_held, m_multi, m_code[W-1:0]);
            else passes++;
            if (strobe) got.push_back(code);
            if (t >= 12 && t < 20 && multi) saw_multi = 1'b1;
        end
        checks++; if (got.size() != 3) $display("FAIL prio_strobes got %0d want 3", got.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== W'(exp_codes[i]))
                $display("FAIL prio_code%0d got %0d want %0d", i, (i < got.size()) ? got[i] : '1, exp_codes[i]);
            else passes++;
        end
        checks++; if (saw_multi !== 1'b1) $display("FAIL prio_multi got %b want 1", saw_multi); else passes++;
    endtask

    task automatic test_lower_add();
        int n = 0;
        in = '0; in[12] = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (t == 10) in[4] = 1'b1;
            if (t == 20) in = '0;
            tick();
            checks++;
            if ({strobe, held, multi, code} !== {m_strobe, m_held, m_multi, m_code[W-1:0]})
                $display("FAIL lower_model t=%0d dut=%b/%b/%b/%0d model=%b/%b/%b/%0d", t,
                         strobe, held, multi, code, m_strobe, m_held, m_multi, m_code[W-1:0]);
            else passes++;
            if (strobe) n++;
            if (t == 19) begin
                checks++; if (code !== 5'd12) $display("FAIL lower_code got %0d want 12", code); else passes++;
                checks++; if (multi !== 1'b1) $display("FAIL lower_multi got %b want 1", multi); else passes++;
                checks++; if (held !== 1'b1)  $display("FAIL lower_held got %b want 1", held);   else passes++;
            end
        end
        checks++; if (n !== 1) $display("FAIL lower_strobes got %0d want 1", n); else passes++;
    endtask

    task automatic test_repeat();
        int exp_off[$];
        int got_off[$];
        bit found = 1'b0;
`ifdef KEY_REPEAT_EN
        for (int o = RD; o <= 100; o += RR) exp_off.push_back(o);
`endif
        in = '0; in[9] = 1'b1;
        for (int t = 1; t <= 20 && !found; t++) begin
            tick();
            if (strobe) found = 1'b1;
        end
        checks++; if (found !== 1'b1) $display("FAIL repeat_accept got none want strobe within 20"); else passes++;
        for (int off = 1; off <= 100; off++) begin
            tick();
            checks++;
            if ({strobe, held, multi, code} !== {m_strobe, m_held, m_multi, m_code[W-1:0]})
                $display("FAIL repeat_model off=%0d dut=%b/%b/%b/%0d model=%b/%b/%b/%0d", off,
                         strobe, held, multi, code, m_strobe, m_held, m_multi, m_code[W-1:0]);
            else passes++;
            if (strobe) got_off.push_back(off);
        end
        checks++;
        if (got_off.size() != exp_off.size())
            $display("FAIL repeat_count got %0d want %0d", got_off.size(), exp_off.size());
        else passes++;
        for (int i = 0; i < exp_off.size() && i < got_off.size(); i++) begin
            checks++;
            if (got_off[i] != exp_off[i]) $display("FAIL repeat_off%0d got %0d want %0d", i, got_off[i], exp_off[i]);
            else passes++;
        end
        checks++; if (code !== 5'd9) $display("FAIL repeat_code got %0d want 9", code); else passes++;
        in = '0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_press();
        int n = 0;
        logic [W-1:0] c = '0;
        in = '0; in[5] = 1'b1;
        repeat (10) tick();
        checks++; if ({held, code} !== {1'b1, 5'd5}) $display("FAIL midrst_pre got %b/%0d want 1/5", held, code); else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({strobe, held, multi, code} !== '0)
            $display("FAIL midrst_clear got %b/%b/%b/%0d want 0/0/0/0", strobe, held, multi, code);
        else passes++;
        @(negedge hz100);
        reset = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            checks++;
            if ({strobe, held, multi, code} !== {m_strobe, m_held, m_multi, m_code[W-1:0]})
                $display("FAIL midrst_model t=%0d dut=%b/%b/%b/%0d model=%b/%b/%b/%0d", t,
                         strobe, held, multi, code, m_strobe, m_held, m_multi, m_code[W-1:0]);
            else passes++;
            if (strobe) begin n++; c = code; end
        end
        checks++; if (n !== 1)     $display("FAIL midrst_strobes got %0d want 1", n); else passes++;
        checks++; if (c !== 5'd5)  $display("FAIL midrst_code got %0d want 5", c);    else passes++;
        in = '0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int len, pos;
        for (int seg = 0; seg < 250; seg++) begin
            len = $urandom_range(1, 12);
            pos = $urandom_range(0, N - 1);
            case ($urandom_range(0, 3))
                0:       in = '0;
                1:       begin in = '0; in[pos] = 1'b1; end
                2:       in[pos] = 1'b1;
                default: in = N'($urandom) & N'($urandom) & N'($urandom);
            endcase
            repeat (len) begin
                tick();
                checks++;
                if ({strobe, held, multi, code} !== {m_strobe, m_held, m_multi, m_code[W-1:0]})
                    $display("FAIL random_model seg=%0d in=%h dut=%b/%b/%b/%0d model=%b/%b/%b/%0d", seg, in,
                             strobe, held, multi, code, m_strobe, m_held, m_multi, m_code[W-1:0]);
                else passes++;
            end
        end
        in = '0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_priority();
        test_lower_add();
        test_repeat();
        test_reset_mid_press();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
